// File: rtl/dmem_port_arbiter.sv
// Arbitrates the shared single-port data memory between the CPU MEM stage and the
// UART debug port; CPU has default priority, a wait counter bounds debug latency.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [0:0] CPU_PRI   = 1'b0;
    localparam logic [0:0] DBG_FORCE = 1'b1;
    localparam logic [3:0] MAX_W     = 4'(MAX_WAIT);

    logic [0:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       cpu_rd_q, cpu_rd_d;
    logic       dbg_rd_q, dbg_rd_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (enable && !reset) begin
            if (state_q == DBG_FORCE) begin
                dbg_gnt = dbg_req;
                cpu_gnt = cpu_req && !dbg_req;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req && !cpu_req;
            end
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt;
    assign mem_en    = cpu_gnt || dbg_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (dbg_gnt) begin
            wait_d = '0;
        end else if (enable && dbg_req && wait_q != MAX_W) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_PRI:   if (wait_d == MAX_W) state_d = DBG_FORCE;
            DBG_FORCE: if (dbg_gnt || !dbg_req) state_d = CPU_PRI;
            default:   state_d = CPU_PRI;
        endcase
    end

    assign cpu_rd_d = cpu_gnt && !cpu_we;
    assign dbg_rd_d = dbg_gnt && !dbg_we;

    // A return tag already set is masked while reset is high so an in-flight read never surfaces.
    assign cpu_rvalid = cpu_rd_q && !reset;
    assign dbg_rvalid = dbg_rd_q && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CPU_PRI;
            wait_q   <= '0;
            cpu_rd_q <= 1'b0;
            dbg_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            cpu_rd_q <= cpu_rd_d;
            dbg_rd_q <= dbg_rd_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a behavioural reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dmem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Physical synchronous-read memory attached to the arbiter.
    logic [DW-1:0] mem_arr [128];
    logic [DW-1:0] mem_rd_q;
    assign mem_rdata = mem_rd_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rd_q <= mem_arr[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who wins, how long debug has been refused, what each read returns.
    logic [DW-1:0] ref_mem [128];
    int            denied;
    bit            dbg_has_priority;
    int            ret_port;
    logic [DW-1:0] ret_data;

    always @(negedge clk) begin
        bit ok, e_cg, e_dg, e_cw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        ok = enable && !reset;
        if (dbg_has_priority) begin
            e_dg = ok && dbg_req;
            e_cg = ok && cpu_req && !dbg_req;
        end else begin
            e_cg = ok && cpu_req;
            e_dg = ok && dbg_req && !cpu_req;
        end
        e_cw   = e_cg ? cpu_we   : (e_dg ? dbg_we   : 1'b0);
        e_addr = e_cg ? cpu_addr : (e_dg ? dbg_addr : '0);
        e_wd   = e_cg ? cpu_wdata: (e_dg ? dbg_wdata: '0);

        check("m_cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
        check("m_dbg_gnt",    32'(dbg_gnt),    32'(e_dg));
        check("m_cpu_stall",  32'(cpu_stall),  32'(cpu_req && !e_cg));
        check("m_mem_en",     32'(mem_en),     32'(e_cg || e_dg));
        check("m_mem_we",     32'(mem_we),     32'(e_cw));
        check("m_mem_addr",   32'(mem_addr),   32'(e_addr));
        check("m_mem_wdata",  mem_wdata,       e_wd);
        check("m_cpu_rvalid", 32'(cpu_rvalid), 32'(ret_port == 1 && !reset));
        check("m_dbg_rvalid", 32'(dbg_rvalid), 32'(ret_port == 2 && !reset));
        check("m_cpu_rdata",  cpu_rdata, (ret_port == 1 && !reset) ? ret_data : '0);
        check("m_dbg_rdata",  dbg_rdata, (ret_port == 2 && !reset) ? ret_data : '0);

        if (reset) begin
            denied = 0;
            dbg_has_priority = 1'b0;
            ret_port = 0;
        end else begin
            ret_port = 0;
            if ((e_cg || e_dg) && !e_cw) begin
                ret_port = e_cg ? 1 : 2;
                ret_data = ref_mem[e_addr];
            end
            if ((e_cg || e_dg) && e_cw) ref_mem[e_addr] = e_wd;
            if (e_dg) denied = 0;
            else if (enable && dbg_req && denied < MW) denied = denied + 1;
            if (!dbg_has_priority) dbg_has_priority = (denied == MW);
            else if (e_dg || !dbg_req) dbg_has_priority = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        mem_arr[127] = 32'hDEAD_BEEF;
        ref_mem[127] = 32'hDEAD_BEEF;
        mem_rd_q = '0;
        denied = 0; dbg_has_priority = 1'b0; ret_port = 0; ret_data = '0;
        reset = 1'b1; enable = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        // Reset: requests present but nothing granted.
        step(); step(); settle();
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        check("rst_wait", 32'(dut.wait_q), 32'd0);

        step(); reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        settle();
        check("idle_mem_en", 32'(mem_en), 32'd0);
        step(); settle();
        check("idle_mem_en2", 32'(mem_en), 32'd0);

        // CPU write 5 to addr 0, then read it back.
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd0; cpu_wdata = 32'h0000_0005;
        settle();
        check("cw_gnt", 32'(cpu_gnt), 32'd1);
        step(); cpu_we = 1'b0;
        settle();
        check("cr_gnt", 32'(cpu_gnt), 32'd1);
        check("cr_no_rvalid_yet", 32'(cpu_rvalid), 32'd0);
        step(); cpu_req = 1'b0;
        settle();
        check("cr_rvalid", 32'(cpu_rvalid), 32'd1);
        check("cr_rdata", cpu_rdata, 32'h0000_0005);
        check("cr_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

        // Continuous contention: debug forced through in cycle MAX_WAIT+1.
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd1;
                dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h7F;
            end
            if (i == 6) dbg_req = 1'b0;
            settle();
            check($sformatf("cont_cpu_gnt_c%0d", i), 32'(cpu_gnt), 32'(i != 5));
            check($sformatf("cont_dbg_gnt_c%0d", i), 32'(dbg_gnt), 32'(i == 5));
            check($sformatf("cont_stall_c%0d", i), 32'(cpu_stall), 32'(i == 5));
            if (i == 6) begin
                check("cont_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
                check("cont_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
            end
        end

        // Uncontended debug read of 0x7F.
        step(); cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h7F;
        settle();
        check("dr_gnt", 32'(dbg_gnt), 32'd1);
        check("dr_wait", 32'(dut.wait_q), 32'd0);
        step(); dbg_req = 1'b0;
        settle();
        check("dr_rvalid", 32'(dbg_rvalid), 32'd1);
        check("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
        check("dr_wait2", 32'(dut.wait_q), 32'd0);

        // Debug poke, CPU reads it back.
        step(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'd3; dbg_wdata = 32'h1234_5678;
        settle();
        check("dp_gnt", 32'(dbg_gnt), 32'd1);
        step(); dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd3;
        settle();
        check("dp_cpu_gnt", 32'(cpu_gnt), 32'd1);
        step(); cpu_req = 1'b0;
        settle();
        check("dp_rdata", cpu_rdata, 32'h1234_5678);

        // Reset lands while a CPU read is in flight.
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd0;
        settle();
        check("rf_gnt", 32'(cpu_gnt), 32'd1);
        step(); cpu_req = 1'b0; reset = 1'b1;
        settle();
        check("rf_rvalid_rst", 32'(cpu_rvalid), 32'd0);
        step(); reset = 1'b0;
        settle();
        check("rf_rvalid_after", 32'(cpu_rvalid), 32'd0);
        check("rf_state", 32'(dut.state_q), 32'd0);
        check("rf_wait", 32'(dut.wait_q), 32'd0);

        // Enable drops with a read in flight and both requests held.
        step(); cpu_req = 1'b1; cpu_addr = 7'd0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'd2;
        settle();
        check("en_c1_cpu", 32'(cpu_gnt), 32'd1);
        step(); settle();
        check("en_c2_cpu", 32'(cpu_gnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) enable = 1'b0;
            settle();
            if (i == 0) check("en_inflight_rvalid", 32'(cpu_rvalid), 32'd1);
            check($sformatf("en_off_cpu_%0d", i), 32'(cpu_gnt), 32'd0);
            check($sformatf("en_off_dbg_%0d", i), 32'(dbg_gnt), 32'd0);
            check($sformatf("en_off_wait_%0d", i), 32'(dut.wait_q), 32'd2);
        end
        step(); enable = 1'b1;
        settle();
        check("en_on_cpu", 32'(cpu_gnt), 32'd1);
        check("en_on_dbg", 32'(dbg_gnt), 32'd0);
        step(); settle();
        check("en_on2_cpu", 32'(cpu_gnt), 32'd1);
        step(); settle();
        check("en_on3_dbg", 32'(dbg_gnt), 32'd1);
        check("en_on3_stall", 32'(cpu_stall), 32'd1);
        step(); cpu_req = 1'b0; dbg_req = 1'b0;
        settle();
        step(); settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
